// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: shares the VGA adapter plot port between two pixel
// requesters (round-robin, one pixel per clock) and a full-screen fill
// engine that pre-empts both while it sweeps every pixel once.
module vga_plot_arbiter #(
    parameter int unsigned SCREEN_W = 160,
    parameter int unsigned SCREEN_H = 120
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       a_valid,
    input  logic [7:0] a_x,
    input  logic [6:0] a_y,
    input  logic [2:0] a_colour,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic [7:0] b_x,
    input  logic [6:0] b_y,
    input  logic [2:0] b_colour,
    output logic       b_ready,
    input  logic       fill_start,
    input  logic [2:0] fill_colour,
    output logic       fill_busy,
    output logic       fill_done,
    output logic       drop,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);

    typedef enum logic {ST_ARB, ST_FILL} state_t;

    // One extra bit so a limit of 256 / 128 still compares correctly.
    localparam logic [8:0] X_LIM  = 9'(SCREEN_W);
    localparam logic [7:0] Y_LIM  = 8'(SCREEN_H);
    localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
    localparam logic [6:0] Y_LAST = 7'(SCREEN_H - 1);

    state_t     state_q, state_d;
    logic       ptr_q, ptr_d;         // 0: A has priority, 1: B has priority
    logic [7:0] fx_q, fx_d;
    logic [6:0] fy_q, fy_d;
    logic [2:0] fcol_q, fcol_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [2:0] c_q, c_d;
    logic       plot_q, plot_d;
    logic       drop_q, drop_d;
    logic       done_q, done_d;
    logic [7:0] sel_x;
    logic [6:0] sel_y;
    logic [2:0] sel_c;

    // Grant logic: blocked during FILL and in the cycle a fill is requested.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (state_q == ST_ARB && !fill_start) begin
            if (a_valid && b_valid) begin
                a_ready = ~ptr_q;
                b_ready = ptr_q;
            end else begin
                a_ready = a_valid;
                b_ready = b_valid;
            end
        end
    end

    // Next-state, sweep counters and registered adapter outputs.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        fx_d    = fx_q;
        fy_d    = fy_q;
        fcol_d  = fcol_q;
        x_d     = x_q;
        y_d     = y_q;
        c_d     = c_q;
        plot_d  = 1'b0;
        drop_d  = 1'b0;
        done_d  = 1'b0;
        sel_x   = a_ready ? a_x      : b_x;
        sel_y   = a_ready ? a_y      : b_y;
        sel_c   = a_ready ? a_colour : b_colour;
        case (state_q)
            ST_ARB: begin
                if (fill_start) begin
                    // First fill pixel (0,0) is issued on the entry edge itself.
                    state_d = ST_FILL;
                    fcol_d  = fill_colour;
                    fx_d    = '0;
                    fy_d    = '0;
                    x_d     = '0;
                    y_d     = '0;
                    c_d     = fill_colour;
                    plot_d  = 1'b1;
                end else if (a_ready || b_ready) begin
                    x_d   = sel_x;
                    y_d   = sel_y;
                    c_d   = sel_c;
                    ptr_d = a_ready;
                    if ({1'b0, sel_x} < X_LIM && {1'b0, sel_y} < Y_LIM) begin
                        plot_d = 1'b1;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
            end
            ST_FILL: begin
                // fx/fy name the pixel currently on the outputs.
                if (fx_q == X_LAST && fy_q == Y_LAST) begin
                    state_d = ST_ARB;
                    done_d  = 1'b1;
                end else begin
                    if (fx_q == X_LAST) begin
                        fx_d = '0;
                        fy_d = fy_q + 7'd1;
                    end else begin
                        fx_d = fx_q + 8'd1;
                    end
                    x_d    = fx_d;
                    y_d    = fy_d;
                    c_d    = fcol_q;
                    plot_d = 1'b1;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_ARB;
            ptr_q   <= 1'b0;
            fx_q    <= '0;
            fy_q    <= '0;
            fcol_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            c_q     <= '0;
            plot_q  <= 1'b0;
            drop_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            fx_q    <= fx_d;
            fy_q    <= fy_d;
            fcol_q  <= fcol_d;
            x_q     <= x_d;
            y_q     <= y_d;
            c_q     <= c_d;
            plot_q  <= plot_d;
            drop_q  <= drop_d;
            done_q  <= done_d;
        end
    end

    assign fill_busy  = (state_q == ST_FILL);
    assign fill_done  = done_q;
    assign drop       = drop_q;
    assign vga_x      = x_q;
    assign vga_y      = y_q;
    assign vga_colour = c_q;
    assign vga_plot   = plot_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Self-checking bench for vga_plot_arbiter against a pixel-index reference model.
module tb_vga_plot_arbiter;

    localparam int W = 160;
    localparam int H = 120;

    logic       clock = 1'b0;
    logic       resetn = 1'b1;
    logic       a_valid = 1'b0, b_valid = 1'b0;
    logic [7:0] a_x = '0, b_x = '0;
    logic [6:0] a_y = '0, b_y = '0;
    logic [2:0] a_colour = '0, b_colour = '0;
    logic       a_ready, b_ready;
    logic       fill_start = 1'b0;
    logic [2:0] fill_colour = '0;
    logic       fill_busy, fill_done, drop, vga_plot;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int   m_ptr;      // requester that wins a tie: 0 = A, 1 = B
    bit   m_fill;
    int   m_n;        // linear index of the fill pixel on the outputs
    int   m_col;
    int   e_x, e_y, e_c;
    bit   e_plot, e_drop, e_done, e_busy;
    bit   exp_ar, exp_br;
    logic obs_ar, obs_br;

    vga_plot_arbiter #(.SCREEN_W(W), .SCREEN_H(H)) dut (
        .clock(clock), .resetn(resetn),
        .a_valid(a_valid), .a_x(a_x), .a_y(a_y), .a_colour(a_colour), .a_ready(a_ready),
        .b_valid(b_valid), .b_x(b_x), .b_y(b_y), .b_colour(b_colour), .b_ready(b_ready),
        .fill_start(fill_start), .fill_colour(fill_colour),
        .fill_busy(fill_busy), .fill_done(fill_done), .drop(drop),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        m_ptr = 0; m_fill = 0; m_n = 0; m_col = 0;
        e_x = 0; e_y = 0; e_c = 0;
        e_plot = 0; e_drop = 0; e_done = 0; e_busy = 0;
    endtask

    task automatic idle_inputs();
        a_valid = 0; b_valid = 0; fill_start = 0;
    endtask

    // One clock: called at posedge+1 with inputs already driven; returns at posedge+1.
    task automatic tick();
        bit start;
        int gx, gy, gc, fc;
        #1;
        obs_ar = a_ready;
        obs_br = b_ready;
        start = !m_fill && fill_start;
        if (m_fill || start) begin
            exp_ar = 0; exp_br = 0;
        end else if (a_valid && b_valid) begin
            exp_ar = (m_ptr == 0); exp_br = (m_ptr == 1);
        end else begin
            exp_ar = a_valid; exp_br = b_valid;
        end
        gx = exp_ar ? int'(a_x) : int'(b_x);
        gy = exp_ar ? int'(a_y) : int'(b_y);
        gc = exp_ar ? int'(a_colour) : int'(b_colour);
        fc = int'(fill_colour);
        @(posedge clock);
        #1;
        e_plot = 0; e_drop = 0; e_done = 0;
        if (m_fill) begin
            if (m_n == W * H - 1) begin
                m_fill = 0; e_done = 1;
            end else begin
                m_n++;
                e_x = m_n % W; e_y = m_n / W; e_c = m_col; e_plot = 1;
            end
        end else if (start) begin
            m_fill = 1; m_n = 0; m_col = fc;
            e_x = 0; e_y = 0; e_c = fc; e_plot = 1;
        end else if (exp_ar || exp_br) begin
            e_x = gx; e_y = gy; e_c = gc;
            if (gx < W && gy < H) e_plot = 1;
            else e_drop = 1;
            m_ptr = exp_ar ? 1 : 0;
        end
        e_busy = m_fill;
    endtask

    task automatic apply_reset();
        idle_inputs();
        resetn = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1;
        @(posedge clock);
        #1;
        model_reset();
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 0;
        #2;
        checks++;
        if ({vga_plot, drop, fill_done, fill_busy, vga_x, vga_y, vga_colour} !== 22'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0",
                     {vga_plot, drop, fill_done, fill_busy, vga_x, vga_y, vga_colour});
        end
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if ({vga_plot, drop, fill_done, fill_busy, vga_x, vga_y, vga_colour, a_ready, b_ready}
                !== {e_plot, e_drop, e_done, e_busy, 8'(e_x), 7'(e_y), 3'(e_c), 2'b00}) begin
                errors++;
                $display("FAIL idle_outputs: cycle %0d got plot=%b drop=%b done=%b busy=%b x=%0d y=%0d c=%0d",
                         i, vga_plot, drop, fill_done, fill_busy, vga_x, vga_y, vga_colour);
            end
        end
    endtask

    task automatic test_a_only();
        a_valid = 1; a_x = 8'd10; a_y = 7'd20; a_colour = 3'd3;
        tick();
        checks++;
        if (obs_ar !== 1'b1 || obs_br !== 1'b0) begin
            errors++;
            $display("FAIL a_only_ready: got a=%b b=%b required a=1 b=0", obs_ar, obs_br);
        end
        checks++;
        if ({vga_plot, drop, vga_x, vga_y, vga_colour} !== {1'b1, 1'b0, 8'd10, 7'd20, 3'd3}) begin
            errors++;
            $display("FAIL a_only_pixel: got plot=%b drop=%b (%0d,%0d,%0d) required plot=1 (10,20,3)",
                     vga_plot, drop, vga_x, vga_y, vga_colour);
        end
        a_valid = 0;
        tick();
        checks++;
        if (vga_plot !== 1'b0 || vga_x !== 8'd10 || vga_y !== 7'd20) begin
            errors++;
            $display("FAIL a_only_hold: got plot=%b x=%0d y=%0d required plot=0 x=10 y=20",
                     vga_plot, vga_x, vga_y);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        a_valid = 1; a_x = 8'd1; a_y = 7'd1; a_colour = 3'd1;
        b_valid = 1; b_x = 8'd2; b_y = 7'd2; b_colour = 3'd2;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (obs_ar !== (i % 2 == 0) || obs_br !== (i % 2 == 1)) begin
                errors++;
                $display("FAIL rr_grant: cycle %0d got a=%b b=%b required a=%b b=%b",
                         i, obs_ar, obs_br, (i % 2 == 0), (i % 2 == 1));
            end
            checks++;
            if (vga_plot !== 1'b1 || vga_x !== ((i % 2 == 0) ? 8'd1 : 8'd2)) begin
                errors++;
                $display("FAIL rr_pixel: cycle %0d got plot=%b x=%0d required plot=1 x=%0d",
                         i, vga_plot, vga_x, (i % 2 == 0) ? 1 : 2);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_out_of_range();
        int xs[3] = '{160, 5, 159};
        int ys[3] = '{5, 120, 119};
        a_valid = 1; a_colour = 3'd7;
        for (int i = 0; i < 3; i++) begin
            a_x = 8'(xs[i]); a_y = 7'(ys[i]);
            tick();
            checks++;
            if (obs_ar !== 1'b1 || vga_plot !== (i == 2) || drop !== (i != 2)) begin
                errors++;
                $display("FAIL range_%0d: got ready=%b plot=%b drop=%b required ready=1 plot=%b drop=%b",
                         i, obs_ar, vga_plot, drop, (i == 2), (i != 2));
            end
        end
        checks++;
        if (vga_x !== 8'd159 || vga_y !== 7'd119) begin
            errors++;
            $display("FAIL range_edge_pixel: got (%0d,%0d) required (159,119)", vga_x, vga_y);
        end
        idle_inputs();
        tick();
        checks++;
        if (drop !== 1'b0 || vga_plot !== 1'b0) begin
            errors++;
            $display("FAIL range_pulse: got drop=%b plot=%b required 0 0", drop, vga_plot);
        end
    endtask

    task automatic test_fill();
        int plots = 0;
        int dones = 0;
        bit finished = 0;
        idle_inputs();
        b_valid = 1; b_x = 8'd30; b_y = 7'd40; b_colour = 3'd6;
        fill_start = 1; fill_colour = 3'd5;
        tick();
        fill_start = 0; fill_colour = 3'd0;
        checks++;
        if (obs_br !== 1'b0) begin
            errors++;
            $display("FAIL fill_entry_block: got b_ready=%b required 0", obs_br);
        end
        for (int cyc = 0; cyc < W * H + 10 && !finished; cyc++) begin
            checks++;
            if ({vga_plot, drop, fill_done, fill_busy, vga_x, vga_y, vga_colour, obs_br}
                !== {e_plot, e_drop, e_done, e_busy, 8'(e_x), 7'(e_y), 3'(e_c), exp_br}) begin
                errors++;
                $display("FAIL fill_step: cycle %0d got plot=%b done=%b busy=%b (%0d,%0d,%0d) brdy=%b required plot=%b done=%b busy=%b (%0d,%0d,%0d) brdy=%b",
                         cyc, vga_plot, fill_done, fill_busy, vga_x, vga_y, vga_colour, obs_br,
                         e_plot, e_done, e_busy, e_x, e_y, e_c, exp_br);
            end
            if (vga_plot === 1'b1) begin
                plots++;
                if (plots == 1 || plots == W || plots == W + 1 || plots == W * H) begin
                    checks++;
                    if (vga_x !== ((plots == W || plots == W * H) ? 8'd159 : 8'd0) ||
                        vga_y !== ((plots == W * H) ? 7'd119 : (plots == W + 1) ? 7'd1 : 7'd0) ||
                        vga_colour !== 3'd5) begin
                        errors++;
                        $display("FAIL fill_landmark: plot #%0d got (%0d,%0d,%0d)",
                                 plots, vga_x, vga_y, vga_colour);
                    end
                end
            end
            if (fill_done === 1'b1) begin
                dones++;
                finished = 1;
            end else begin
                fill_start = (plots == 1000);
                fill_colour = (plots == 1000) ? 3'd2 : 3'd0;
                tick();
                fill_start = 0;
            end
        end
        checks++;
        if (!finished || plots != W * H || dones != 1) begin
            errors++;
            $display("FAIL fill_totals: got plots=%0d dones=%0d finished=%0b required plots=%0d dones=1 finished=1",
                     plots, dones, finished, W * H);
        end
        tick();
        checks++;
        if (obs_br !== 1'b1 || vga_plot !== 1'b1 || vga_x !== 8'd30 || vga_y !== 7'd40 || fill_done !== 1'b0) begin
            errors++;
            $display("FAIL fill_then_b: got brdy=%b plot=%b (%0d,%0d) done=%b required 1 1 (30,40) 0",
                     obs_br, vga_plot, vga_x, vga_y, fill_done);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid_fill();
        idle_inputs();
        fill_start = 1; fill_colour = 3'd6;
        tick();
        fill_start = 0;
        for (int i = 0; i < 600 && m_n < 500; i++) tick();
        checks++;
        if (vga_plot !== 1'b1 || fill_busy !== 1'b1 || vga_x !== 8'(500 % W)) begin
            errors++;
            $display("FAIL mid_fill_pre: got plot=%b busy=%b x=%0d required 1 1 %0d",
                     vga_plot, fill_busy, vga_x, 500 % W);
        end
        #1 resetn = 0;
        #1;
        checks++;
        if ({vga_plot, drop, fill_done, fill_busy, vga_x, vga_y, vga_colour} !== 22'd0) begin
            errors++;
            $display("FAIL mid_fill_async: got %h required 0",
                     {vga_plot, drop, fill_done, fill_busy, vga_x, vga_y, vga_colour});
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1;
        @(posedge clock);
        #1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (fill_done !== 1'b0 || fill_busy !== 1'b0 || vga_plot !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle: cycle %0d got done=%b busy=%b plot=%b required 0 0 0",
                         i, fill_done, fill_busy, vga_plot);
            end
        end
        a_valid = 1; a_x = 8'd7; a_y = 7'd8; a_colour = 3'd1;
        tick();
        checks++;
        if (obs_ar !== 1'b1 || {vga_plot, vga_x, vga_y, vga_colour} !== {1'b1, 8'd7, 7'd8, 3'd1}) begin
            errors++;
            $display("FAIL post_reset_a: got ready=%b plot=%b (%0d,%0d,%0d) required 1 1 (7,8,1)",
                     obs_ar, vga_plot, vga_x, vga_y, vga_colour);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        idle_inputs();
        for (int i = 0; i < 400; i++) begin
            if (!a_valid || obs_ar) begin
                a_valid = 1'($urandom_range(0, 1));
                a_x = 8'($urandom_range(0, 170));
                a_y = 7'($urandom_range(0, 127));
                a_colour = 3'($urandom);
            end
            if (!b_valid || obs_br) begin
                b_valid = 1'($urandom_range(0, 1));
                b_x = 8'($urandom_range(0, 170));
                b_y = 7'($urandom_range(0, 127));
                b_colour = 3'($urandom);
            end
            tick();
            checks++;
            if ({obs_ar, obs_br, vga_plot, drop, fill_done, fill_busy}
                !== {exp_ar, exp_br, e_plot, e_drop, e_done, e_busy}) begin
                errors++;
                $display("FAIL rand_ctrl: cycle %0d got ar=%b br=%b plot=%b drop=%b required ar=%b br=%b plot=%b drop=%b",
                         i, obs_ar, obs_br, vga_plot, drop, exp_ar, exp_br, e_plot, e_drop);
            end
            if (e_plot) begin
                checks++;
                if ({vga_x, vga_y, vga_colour} !== {8'(e_x), 7'(e_y), 3'(e_c)}) begin
                    errors++;
                    $display("FAIL rand_pixel: cycle %0d got (%0d,%0d,%0d) required (%0d,%0d,%0d)",
                             i, vga_x, vga_y, vga_colour, e_x, e_y, e_c);
                end
            end
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        model_reset();
        obs_ar = 0; obs_br = 0; exp_ar = 0; exp_br = 0;
        test_reset();
        test_a_only();
        test_back_to_back();
        test_out_of_range();
        test_fill();
        test_reset_mid_fill();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
